// File: rtl/pwm_ctrl.sv
// PWM configuration controller: bus register file with per-channel shadow settings that
// commit atomically to all channels at a timebase wrap. Macro PWM_CTRL_IRQ_EN adds irq_o.
module pwm_ctrl #(
    parameter int NumCh   = 12,
    parameter int CtrSize = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     device_req_i,
    input  logic [31:0]              device_addr_i,
    input  logic                     device_we_i,
    input  logic [3:0]               device_be_i,
    input  logic [31:0]              device_wdata_i,
    output logic                     device_rvalid_o,
    output logic [31:0]              device_rdata_o,
    output logic                     device_err_o,
    output logic [NumCh*CtrSize-1:0] pulse_width_o,
    output logic [NumCh*CtrSize-1:0] max_counter_o,
    output logic [NumCh-1:0]         pwm_en_o,
    output logic                     sync_o,
    output logic                     irq_o
);
    typedef logic [CtrSize-1:0] ctr_t;

    logic [NumCh-1:0] r_en;
    ctr_t             r_timebase;
    ctr_t             r_tb_cnt;
    logic             r_pending;
    logic             r_done;
    logic             r_sync;
    ctr_t             r_pw_sh  [NumCh];
    ctr_t             r_mc_sh  [NumCh];
    ctr_t             r_pw_act [NumCh];
    ctr_t             r_mc_act [NumCh];
    logic             r_rvalid;
    logic             r_err;
    logic [31:0]      r_rdata;
`ifdef PWM_CTRL_IRQ_EN
    logic             r_irq_en;
`endif

    logic [11:0] w_off;
    logic [4:0]  w_ch;
    logic        w_sel_ctrl;
    logic        w_sel_status;
    logic        w_sel_commit;
    logic        w_sel_tb;
    logic        w_sel_ch;
    logic        w_hit;
    logic        w_wr;
    logic [31:0] w_bmask;
    logic [31:0] w_cur;
    logic [31:0] w_merged;
    logic        w_wrap;
    logic        w_commit;
    logic        w_unused;

    assign w_off        = device_addr_i[11:0];
    assign w_ch         = w_off[7:3];
    assign w_sel_ctrl   = (w_off == 12'h000);
    assign w_sel_status = (w_off == 12'h004);
    assign w_sel_commit = (w_off == 12'h008);
    assign w_sel_tb     = (w_off == 12'h00C);
    assign w_sel_ch     = (w_off[11:8] == 4'h1) && (w_off[1:0] == 2'b00) && (int'(w_ch) < NumCh);
    assign w_hit        = w_sel_ctrl | w_sel_status | w_sel_commit | w_sel_tb | w_sel_ch;
    assign w_wr         = device_req_i & device_we_i & w_hit;

    assign w_bmask  = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                       {8{device_be_i[1]}}, {8{device_be_i[0]}}};
    // Byte-enabled write: unselected bytes keep the register's current value.
    assign w_merged = (w_cur & ~w_bmask) | (device_wdata_i & w_bmask);
    assign w_unused = ^{device_addr_i[31:12], w_merged};

    assign w_wrap   = (r_tb_cnt >= r_timebase);
    assign w_commit = r_pending & w_wrap;

    // Read view of the addressed register; fields are zero-extended to 32 bits.
    always_comb begin
        // NOTE: default first so no decode path leaves w_cur unassigned (no latch).
        w_cur = '0;
        if (w_sel_ctrl) begin
            w_cur[NumCh-1:0] = r_en;
`ifdef PWM_CTRL_IRQ_EN
            w_cur[31] = r_irq_en;
`endif
        end else if (w_sel_status) begin
            w_cur[1:0] = {r_done, r_pending};
        end else if (w_sel_tb) begin
            w_cur[CtrSize-1:0] = r_timebase;
        end else if (w_sel_ch) begin
            for (int i = 0; i < NumCh; i++) begin
                if (w_ch == 5'(i)) begin
                    w_cur[CtrSize-1:0] = w_off[2] ? r_mc_sh[i] : r_pw_sh[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en       <= '0;
            r_timebase <= '1;
            r_tb_cnt   <= '0;
            r_pending  <= 1'b0;
            r_done     <= 1'b0;
            r_sync     <= 1'b0;
`ifdef PWM_CTRL_IRQ_EN
            r_irq_en   <= 1'b0;
`endif
            // NOTE: shadow/active arrays are configuration flops with defined reset
            // values (not a RAM), so every element is reset explicitly.
            for (int i = 0; i < NumCh; i++) begin
                r_pw_sh[i]  <= '0;
                r_mc_sh[i]  <= '1;
                r_pw_act[i] <= '0;
                r_mc_act[i] <= '1;
            end
        end else begin
            r_tb_cnt <= w_wrap ? '0 : r_tb_cnt + ctr_t'(1);
            r_sync   <= w_commit;

            if (w_wr && w_sel_ctrl) begin
                r_en <= w_merged[NumCh-1:0];
`ifdef PWM_CTRL_IRQ_EN
                r_irq_en <= w_merged[31];
`endif
            end
            if (w_wr && w_sel_tb) begin
                r_timebase <= w_merged[CtrSize-1:0];
            end

            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (w_wr && w_sel_commit && device_be_i[0]) begin
                r_pending <= 1'b1;
            end

            if (w_commit) begin
                r_done <= 1'b1;
            end else if (w_wr && w_sel_status && device_be_i[0] && device_wdata_i[1]) begin
                r_done <= 1'b0;
            end

            // NOTE: non-blocking assignments make every active register take the
            // pre-edge shadow, so a shadow write in the commit cycle stays in the shadow.
            for (int i = 0; i < NumCh; i++) begin
                if (w_commit) begin
                    r_pw_act[i] <= r_pw_sh[i];
                    r_mc_act[i] <= r_mc_sh[i];
                end
                if (w_wr && w_sel_ch && (w_ch == 5'(i))) begin
                    if (w_off[2]) r_mc_sh[i] <= w_merged[CtrSize-1:0];
                    else          r_pw_sh[i] <= w_merged[CtrSize-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_err    <= device_req_i & ~w_hit;
            r_rdata  <= (device_req_i && !device_we_i && w_hit) ? w_cur : '0;
        end
    end

    always_comb begin
        pulse_width_o = '0;
        max_counter_o = '0;
        for (int i = 0; i < NumCh; i++) begin
            pulse_width_o[i*CtrSize +: CtrSize] = r_en[i] ? r_pw_act[i] : '0;
            max_counter_o[i*CtrSize +: CtrSize] = r_mc_act[i];
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_err_o    = r_err;
    assign device_rdata_o  = r_rdata;
    assign pwm_en_o        = r_en;
    assign sync_o          = r_sync;

`ifdef PWM_CTRL_IRQ_EN
    assign irq_o = r_done & r_irq_en;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: bus responses go through a scoreboard queue and
// sync_o is compared every cycle against a small commit/timebase reference model.
module tb_pwm_ctrl;
    localparam int NumCh   = 12;
    localparam int CtrSize = 8;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     device_req_i;
    logic [31:0]              device_addr_i;
    logic                     device_we_i;
    logic [3:0]               device_be_i;
    logic [31:0]              device_wdata_i;
    logic                     device_rvalid_o;
    logic [31:0]              device_rdata_o;
    logic                     device_err_o;
    logic [NumCh*CtrSize-1:0] pulse_width_o;
    logic [NumCh*CtrSize-1:0] max_counter_o;
    logic [NumCh-1:0]         pwm_en_o;
    logic                     sync_o;
    logic                     irq_o;

    pwm_ctrl #(.NumCh(NumCh), .CtrSize(CtrSize)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .device_req_i   (device_req_i),
        .device_addr_i  (device_addr_i),
        .device_we_i    (device_we_i),
        .device_be_i    (device_be_i),
        .device_wdata_i (device_wdata_i),
        .device_rvalid_o(device_rvalid_o),
        .device_rdata_o (device_rdata_o),
        .device_err_o   (device_err_o),
        .pulse_width_o  (pulse_width_o),
        .max_counter_o  (max_counter_o),
        .pwm_en_o       (pwm_en_o),
        .sync_o         (sync_o),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model of timebase, pending, done and the sync pulse, built from bus snoops.
    logic [7:0] m_cnt, m_tb;
    logic       m_pending, m_done, m_sync, m_wrap, m_wr;
    assign m_wrap = (m_cnt >= m_tb);
    assign m_wr   = device_req_i & device_we_i;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cnt     <= 8'h00;
            m_tb      <= 8'hFF;
            m_pending <= 1'b0;
            m_done    <= 1'b0;
            m_sync    <= 1'b0;
        end else begin
            m_cnt  <= m_wrap ? 8'h00 : m_cnt + 8'h01;
            m_sync <= m_pending & m_wrap;
            if (m_pending && m_wrap) m_pending <= 1'b0;
            else if (m_wr && device_addr_i[11:0] == 12'h008 && device_be_i[0]) m_pending <= 1'b1;
            if (m_pending && m_wrap) m_done <= 1'b1;
            else if (m_wr && device_addr_i[11:0] == 12'h004 && device_be_i[0] && device_wdata_i[1])
                m_done <= 1'b0;
            if (m_wr && device_addr_i[11:0] == 12'h00C && device_be_i[0]) m_tb <= device_wdata_i[7:0];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
        string       tag;
    } resp_t;
    resp_t sb_q[$];

    always @(negedge clk_i) begin
        resp_t e;
        if (rst_ni) begin
            check("sync_vs_model", sync_o, m_sync);
            if (device_rvalid_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_rdata"}, device_rdata_o, e.rdata);
                    check({e.tag, "_err"}, device_err_o, e.err);
                    check({e.tag, "_latency"}, cyc - e.cyc, 32'd1);
                end
            end else begin
                check("rdata_idle", device_rdata_o, 32'd0);
            end
        end
    end

    function automatic logic [7:0] pw(input int i);
        return pulse_width_o[i*CtrSize +: CtrSize];
    endfunction

    function automatic logic [7:0] mc(input int i);
        return max_counter_o[i*CtrSize +: CtrSize];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Issued at posedge+1; the request is sampled at the next edge.
    task automatic bus(input string tag, input logic we, input logic [11:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        resp_t e;
        device_req_i   = 1'b1;
        device_we_i    = we;
        device_addr_i  = {20'h80003, addr};
        device_be_i    = be;
        device_wdata_i = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        device_req_i   = 1'b0;
        device_we_i    = 1'b0;
        device_be_i    = 4'h0;
        device_wdata_i = '0;
    endtask

    task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] data);
        bus(tag, 1'b1, addr, 4'hF, data, 32'd0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus(tag, 1'b0, addr, 4'hF, 32'd0, exp, 1'b0);
    endtask

    task automatic wait_sync(input string tag);
        int n = 0;
        while (sync_o !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check({tag, "_sync_seen"}, sync_o, 32'd1);
    endtask

    // Leaves the bench in a cycle whose closing edge is a wrap (and a commit if asked).
    task automatic wait_wrap(input string tag, input logic need_pending);
        int n = 0;
        while (!(m_wrap && (!need_pending || m_pending)) && n < 40) begin
            tick(1);
            n++;
        end
        check({tag, "_wrap_found"}, 32'(n < 40), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int syncs;
        device_req_i   = 1'b0;
        device_addr_i  = '0;
        device_we_i    = 1'b0;
        device_be_i    = 4'h0;
        device_wdata_i = '0;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_en", pwm_en_o, 32'd0);
        check("rst_sync", sync_o, 32'd0);
        check("rst_rvalid", device_rvalid_o, 32'd0);
        for (int i = 0; i < NumCh; i++) begin
            check($sformatf("rst_pw%0d", i), pw(i), 32'h00);
            check($sformatf("rst_mc%0d", i), mc(i), 32'hFF);
        end
        @(negedge clk_i) rst_ni = 1'b1;
        tick(1);

        rd("t1_status", 12'h004, 32'h0);
        rd("t1_ctrl", 12'h000, 32'h0);
        rd("t1_tb", 12'h00C, 32'hFF);
        rd("t1_mc0_sh", 12'h104, 32'hFF);
        rd("t1_commit", 12'h008, 32'h0);

        // Basic commit of ch3
        wr("t2_ctrl", 12'h000, 32'h8);
        check("t2_en", pwm_en_o, 32'h8);
        wr("t2_pw3", 12'h118, 32'h40);
        check("t2_pw3_uncommitted", pw(3), 32'h00);
        wr("t2_tb", 12'h00C, 32'h0F);
        wr("t2_commit", 12'h008, 32'h1);
        rd("t2_status_pend", 12'h004, 32'h1);
        wait_sync("t2");
        check("t2_pw3", pw(3), 32'h40);
        check("t2_mc3", mc(3), 32'hFF);
        tick(1);
        check("t2_sync_one_cycle", sync_o, 32'd0);
        rd("t2_status_done", 12'h004, 32'h2);

        // COMMIT landing on a wrap edge waits for the following wrap
        wr("t3_pw3", 12'h118, 32'h22);
        wait_wrap("t3", 1'b0);
        wr("t3_commit", 12'h008, 32'h1);
        check("t3_no_sync_now", sync_o, 32'd0);
        check("t3_pw3_hold", pw(3), 32'h40);
        tick(15);
        check("t3_pw3_before", pw(3), 32'h40);
        check("t3_sync_before", sync_o, 32'd0);
        tick(1);
        check("t3_pw3_after", pw(3), 32'h22);
        check("t3_sync_after", sync_o, 32'd1);

        // Error decode and byte enables
        bus("t4_rd_ch12", 1'b0, 12'h160, 4'hF, 32'h0, 32'h0, 1'b1);
        bus("t4_wr_ch12", 1'b1, 12'h160, 4'hF, 32'hFF, 32'h0, 1'b1);
        bus("t4_rd_010", 1'b0, 12'h010, 4'hF, 32'h0, 32'h0, 1'b1);
        bus("t4_wr_010", 1'b1, 12'h010, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        rd("t4_ctrl_same", 12'h000, 32'h8);
        bus("t4_ctrl_be1", 1'b1, 12'h000, 4'b0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
        rd("t4_ctrl_byte", 12'h000, 32'hF08);
        bus("t4_tb_be1", 1'b1, 12'h00C, 4'b0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
        rd("t4_tb_same", 12'h00C, 32'h0F);

        // Enable mask gating and max_counter on a disabled channel
        wr("t5_ctrl", 12'h000, 32'h1);
        wr("t5_pw0", 12'h100, 32'h80);
        wr("t5_pw1", 12'h108, 32'h80);
        wr("t5_mc1", 12'h10C, 32'h33);
        wr("t5_commit", 12'h008, 32'h1);
        wait_sync("t5");
        check("t5_pw0", pw(0), 32'h80);
        check("t5_pw1_off", pw(1), 32'h00);
        check("t5_mc1_off", mc(1), 32'h33);
        rd("t5_pw1_sh", 12'h108, 32'h80);
`ifdef PWM_CTRL_IRQ_EN
        wr("t5_ctrl_irq", 12'h000, 32'h8000_0001);
        check("t5_irq_on", irq_o, 32'd1);
        wr("t5_w1c", 12'h004, 32'h2);
        check("t5_irq_off", irq_o, 32'd0);
`else
        wr("t5_ctrl_b31", 12'h000, 32'h8000_0001);
        rd("t5_ctrl_b31_rd", 12'h000, 32'h1);
        check("t5_irq_tied", irq_o, 32'd0);
`endif

        // Shadow write and W1C landing on the commit edge
        wr("t6_ctrl", 12'h000, 32'h7);
        wr("t6_pw2", 12'h110, 32'h11);
        wr("t6_commit", 12'h008, 32'h1);
        wait_wrap("t6a", 1'b1);
        wr("t6_pw2_late", 12'h110, 32'h55);
        check("t6_pw2_pre", pw(2), 32'h11);
        rd("t6_pw2_sh", 12'h110, 32'h55);
        rd("t6_status", 12'h004, 32'h2);
        wr("t6_commit2", 12'h008, 32'h1);
        wait_wrap("t6b", 1'b1);
        wr("t6_w1c_race", 12'h004, 32'h2);
        check("t6_pw2_second", pw(2), 32'h55);
        rd("t6_done_kept", 12'h004, 32'h2);
        wr("t6_w1c", 12'h004, 32'h2);
        rd("t6_done_clr", 12'h004, 32'h0);

        // TIMEBASE=0: commit one cycle after the COMMIT write is taken
        wr("t7_tb0", 12'h00C, 32'h0);
        wr("t7_pw0", 12'h100, 32'h90);
        wr("t7_commit", 12'h008, 32'h1);
        tick(1);
        check("t7_sync", sync_o, 32'd1);
        check("t7_pw0", pw(0), 32'h90);

        // Reset with a commit pending
        wr("t8_tb", 12'h00C, 32'h0F);
        wr("t8_pw0", 12'h100, 32'h77);
        wr("t8_commit", 12'h008, 32'h1);
        rd("t8_pending", 12'h004, {30'd0, m_done, m_pending});
        tick(1);
        @(negedge clk_i) rst_ni = 1'b0;
        #1;
        check("t8_rst_en", pwm_en_o, 32'd0);
        check("t8_rst_sync", sync_o, 32'd0);
        check("t8_rst_pw0", pw(0), 32'h00);
        check("t8_rst_mc1", mc(1), 32'hFF);
        check("t8_rst_rdata", device_rdata_o, 32'd0);
        check("t8_rst_irq", irq_o, 32'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        tick(1);
        syncs = 0;
        for (int i = 0; i < 40; i++) begin
            if (sync_o === 1'b1) syncs++;
            tick(1);
        end
        check("t8_no_sync", syncs, 32'd0);
        rd("t8_status", 12'h004, 32'h0);
        rd("t8_tb", 12'h00C, 32'hFF);
        rd("t8_pw0_sh", 12'h100, 32'h0);

        tick(3);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
